// File: rtl/dglk_playback_sequencer.sv
// Playback sequencer for the digital-lock playback engine: drives {p_ena, tun_upd, r_rst, w_rst}.
// Optional external-trigger WAIT state enabled by defining DGLK_PBK_TRIG_EN.
//
// state    | meaning
// IDLE     | no playback, CLEAR/TUNE/START/LOOP accepted
// WAIT_TRG | playback armed, waiting for ext_trg (DGLK_PBK_TRIG_EN only)
// ARM      | r_rst pulsed on entry, then ARM_LAT cycles of read-RAM latency
// RUN      | p_ena high, remaining sample count decrements each cycle
module dglk_playback_sequencer #(
  parameter int W_APB   = 10,
  parameter int W_CNT   = 24,
  parameter int ARM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  input  logic [2:0]       cmd_op,
  input  logic [W_APB-1:0] cmd_adr,
  input  logic [W_CNT-1:0] cmd_len,
  input  logic             ext_trg,
  output logic [4:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  localparam int W_ARM = (ARM_LAT > 0) ? $clog2(ARM_LAT + 1) : 1;

  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_TUNE  = 3'd2;
  localparam logic [2:0] OP_START = 3'd3;
  localparam logic [2:0] OP_STOP  = 3'd4;
  localparam logic [2:0] OP_LOOP  = 3'd5;

  typedef enum logic [1:0] {IDLE, WAIT_TRG, ARM, RUN} state_t;

  state_t           state;
  logic [W_ARM-1:0] arm_cnt;
  logic [W_CNT-1:0] rem_cnt;
  logic [W_CNT-1:0] len_q;
  logic [W_APB-1:0] adr_q;
  logic             loop_q;
  logic             w_rst_q, r_rst_q, tun_upd_q, p_ena_q;
  logic             done_q, err_q;

  logic is_clr, is_tun, is_play, is_stop, is_rej;
  logic unused_sink;

  assign is_clr  = cmd_vld && (cmd_op == OP_CLEAR);
  assign is_tun  = cmd_vld && (cmd_op == OP_TUNE);
  assign is_play = cmd_vld && ((cmd_op == OP_START) || (cmd_op == OP_LOOP));
  assign is_stop = cmd_vld && (cmd_op == OP_STOP);
  assign is_rej  = cmd_vld && ((cmd_op > OP_LOOP) || (busy && (is_clr || is_play)));

  assign busy    = (state != IDLE);
  assign ctrl    = {1'b0, p_ena_q, tun_upd_q, r_rst_q, w_rst_q};
  assign done    = done_q;
  assign cmd_err = err_q;

  // adr_q is the preload address held for the engine's read-pointer register.
`ifdef DGLK_PBK_TRIG_EN
  assign unused_sink = ^adr_q;
`else
  assign unused_sink = ^{adr_q, ext_trg};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arm_cnt   <= '0;
      rem_cnt   <= '0;
      len_q     <= '0;
      adr_q     <= '0;
      loop_q    <= 1'b0;
      w_rst_q   <= 1'b0;
      r_rst_q   <= 1'b0;
      tun_upd_q <= 1'b0;
      p_ena_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      w_rst_q   <= 1'b0;
      r_rst_q   <= 1'b0;
      tun_upd_q <= is_tun;
      done_q    <= 1'b0;
      err_q     <= is_rej;
      case (state)
        IDLE: begin
          p_ena_q <= 1'b0;
          if (is_clr) w_rst_q <= 1'b1;
          if (is_play) begin
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              len_q   <= cmd_len;
              adr_q   <= cmd_adr;
              rem_cnt <= cmd_len;
              loop_q  <= (cmd_op == OP_LOOP);
`ifdef DGLK_PBK_TRIG_EN
              state   <= WAIT_TRG;
`else
              state   <= ARM;
              r_rst_q <= 1'b1;
              arm_cnt <= W_ARM'(ARM_LAT);
`endif
            end
          end
        end
`ifdef DGLK_PBK_TRIG_EN
        WAIT_TRG: begin
          if (is_stop) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (ext_trg) begin
            state   <= ARM;
            r_rst_q <= 1'b1;
            arm_cnt <= W_ARM'(ARM_LAT);
          end
        end
`endif
        ARM: begin
          if (is_stop) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (arm_cnt == '0) begin
            state   <= RUN;
            p_ena_q <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt - W_ARM'(1);
          end
        end
        RUN: begin
          if (is_stop) begin
            state   <= IDLE;
            p_ena_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (rem_cnt == W_CNT'(1)) begin
            p_ena_q <= 1'b0;
            rem_cnt <= len_q;
            if (!loop_q) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
`ifdef DGLK_PBK_TRIG_EN
              state   <= WAIT_TRG;
`else
              state   <= ARM;
              r_rst_q <= 1'b1;
              arm_cnt <= W_ARM'(ARM_LAT);
`endif
            end
          end else begin
            rem_cnt <= rem_cnt - W_CNT'(1);
          end
        end
        default: begin
          state   <= IDLE;
          p_ena_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dglk_playback_sequencer.md
Name: dglk_playback_sequencer

Overview:
Sequencer that drives the 5-bit control word of the digital-lock playback engine: write-pointer clear, read-pointer preload, tune update and playback enable. It accepts single-cycle commands from the RTMQ core (decoded by a GP register upstream) and plays a programmed number of samples from a start address. It reports busy/done status back to the core.

Parameters:
W_APB, 10, playback memory address width (matches playback engine)
W_CNT, 24, playback sample-count width
ARM_LAT, 2, cycles between r_rst pulse and first p_ena (read-RAM latency)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_vld  in  1  command strobe, one cycle
cmd_op  in  3  opcode: 0 NOP, 1 CLEAR, 2 TUNE, 3 START, 4 STOP, 5 LOOP
cmd_adr  in  W_APB  start address for START/LOOP
cmd_len  in  W_CNT  sample count for START/LOOP (0 = no playback)
ext_trg  in  1  external start trigger (used only with optional feature)
ctrl  out  5  {0, p_ena, tun_upd, r_rst, w_rst}; bit4 always 0
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on playback completion or STOP
cmd_err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset: state IDLE; ctrl=0, busy=0, done=0, cmd_err=0; counters cleared, loop flag cleared.
- ctrl is registered: a command accepted in cycle N affects ctrl in cycle N+1.
- IDLE:
  - CLEAR: w_rst=1 for exactly one cycle; stay IDLE.
  - TUNE: tun_upd=1 for exactly one cycle; stay IDLE.
  - START/LOOP with cmd_len!=0: latch adr/len, latch loop flag (LOOP=1), go ARM.
  - START/LOOP with cmd_len==0: done pulse next cycle, stay IDLE.
  - STOP, NOP: ignored, no error.
- ARM: r_rst=1 in the first ARM cycle only; then hold for ARM_LAT further cycles with p_ena=0; go RUN.
- RUN: p_ena=1 every cycle; remaining count decrements each cycle, starting at latched len. When it reaches 1 and the cycle completes:
  - loop flag=0: go IDLE; p_ena drops next cycle; done pulses that cycle. p_ena is high exactly len cycles.
  - loop flag=1: reload count, go ARM (r_rst re-pulsed; gap of ARM_LAT+1 cycles with p_ena=0). No done pulse.
- STOP in ARM or RUN: next cycle p_ena=0 and r_rst=0, state IDLE, done pulse.
- While busy:
  - TUNE is accepted: tun_upd pulses one cycle, p_ena is unaffected.
  - CLEAR, START and LOOP are rejected: cmd_err pulses, state unchanged.
  - Opcodes 6/7 in any state: cmd_err pulse, no other effect.
- Simultaneous-event priorities:
  - rst overrides everything.
  - In RUN, STOP arriving in the final-count cycle: treat as STOP; single done pulse, no loop reload.
- Count width: decrement is W_CNT-bit unsigned, no wrap. Max len 2^W_CNT-1.
- Outputs of ctrl bits 0-2 are never high for more than one consecutive cycle except r_rst re-pulses separated by RUN.

Optional Feature:
DGLK_PBK_TRIG_EN: when defined, START/LOOP from IDLE enter a WAIT state (busy=1, ctrl=0) and proceed to ARM on the first cycle with ext_trg=1; ext_trg is sampled only in WAIT. STOP in WAIT returns to IDLE with a done pulse. In looped mode each reload also re-enters WAIT. When undefined, there is no WAIT state, ext_trg is unused, and START goes directly to ARM.

Test Plan:
- Reset, then CLEAR and TUNE in IDLE -> w_rst high exactly 1 cycle after the first command, tun_upd high exactly 1 cycle after the second; busy stays 0.
- START adr=0x10 len=5, ARM_LAT=2 -> r_rst at N+1; p_ena high cycles N+4..N+8 (5 cycles); done at N+9; busy low from N+9.
- LOOP len=3 run for 3 iterations then STOP -> p_ena bursts of 3 separated by 3-cycle gaps each containing one r_rst; single done after STOP.
- START while RUN, and opcode 7 in IDLE -> cmd_err pulse each time; p_ena sequence unchanged.
- START len=0 -> no r_rst, no p_ena, done pulse 1 cycle later.
- rst asserted mid-RUN -> next cycle ctrl=0, busy=0, no done; (with DGLK_PBK_TRIG_EN) START then ext_trg after 10 cycles -> r_rst one cycle after trigger.
